// File: rtl/counter_mode_pkg.sv
// Shared types and constants for the sequenced LED counter controller.
// Provides the mode encoding, speed ceiling, key bit positions and the
// mode sequencing helper used by counter_mode_ctrl.
package counter_mode_pkg;

    typedef enum logic [1:0] {
        RUN_UP   = 2'd0,
        RUN_DOWN = 2'd1,
        PAUSE    = 2'd2,
        MANUAL   = 2'd3
    } mode_t;

    localparam logic [1:0]  SPEED_MAX = 2'd3;
    localparam int unsigned KEY_MODE  = 0;
    localparam int unsigned KEY_PLUS  = 1;
    localparam int unsigned KEY_MINUS = 2;

    // Mode key cycles RUN_UP -> RUN_DOWN -> PAUSE -> MANUAL -> RUN_UP.
    function automatic mode_t next_mode(input mode_t m);
        mode_t n;
        case (m)
            RUN_UP:   n = RUN_DOWN;
            RUN_DOWN: n = PAUSE;
            PAUSE:    n = MANUAL;
            default:  n = RUN_UP;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer with press detection.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset (returns to released state)
//   key_n   - raw active-low key, asynchronous to clk
//   pressed - one-cycle pulse on an accepted released->pressed transition
module key_debounce #(
    parameter int unsigned DEBOUNCE_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pressed
);

    logic                  sync0;
    logic                  sync1;
    logic                  state;
    logic [DEBOUNCE_W-1:0] stable_cnt;

    // The synced level must disagree with the accepted state for
    // 2^DEBOUNCE_W consecutive cycles before it is taken over.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0      <= 1'b0;
            sync1      <= 1'b0;
            state      <= 1'b0;
            stable_cnt <= '0;
            pressed    <= 1'b0;
        end else begin
            sync0   <= ~key_n;
            sync1   <= sync0;
            pressed <= 1'b0;
            if (sync1 == state) begin
                stable_cnt <= '0;
            end else if (stable_cnt == '1) begin
                state      <= sync1;
                stable_cnt <= '0;
                pressed    <= sync1;
            end else begin
                stable_cnt <= stable_cnt + DEBOUNCE_W'(1);
            end
        end
    end

endmodule

// File: rtl/counter_mode_ctrl.sv
// Key-driven controller sequencing a W-bit LED counter through run-up,
// run-down, pause and manual-step modes, with a speed-selectable tick.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   key   - raw active-low keys: [0]=mode, [1]=plus, [2]=minus
//   led   - active-low display of the counter (~cnt)
//   mode  - current mode (0 RUN_UP, 1 RUN_DOWN, 2 PAUSE, 3 MANUAL)
//   speed - current speed index 0..3
//   tick  - one-cycle prescaler tick, registered
module counter_mode_ctrl
    import counter_mode_pkg::*;
#(
    parameter int unsigned W          = 8,
    parameter int unsigned PRESCALE_W = 24,
    parameter int unsigned DEBOUNCE_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2:0]     key,
    output logic [W-1:0]   led,
    output logic [1:0]     mode,
    output logic [1:0]     speed,
    output logic           tick
);

    localparam logic [PRESCALE_W-1:0] PSC_ONES = '1;

    logic [2:0]            press;
    mode_t                 mode_q, mode_d;
    logic [1:0]            speed_q, speed_d;
    logic [W-1:0]          cnt_q, cnt_d;
    logic [PRESCALE_W-1:0] psc_q;
    logic [PRESCALE_W-1:0] psc_last;
    logic                  tick_q;
    logic                  tick_now;
    logic                  plus_only;
    logic                  minus_only;
    logic                  changed;

    for (genvar i = 0; i < 3; i++) begin : g_key
        key_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_db (
            .clk     (clk),
            .rst     (rst),
            .key_n   (key[i]),
            .pressed (press[i])
        );
    end

    // Period 2^(PRESCALE_W-2*speed): wrap value is all-ones shifted down.
    always_comb begin
        psc_last = PSC_ONES >> {speed_q, 1'b0};
        tick_now = (psc_q == psc_last);
    end

    always_comb begin
        mode_d     = mode_q;
        speed_d    = speed_q;
        cnt_d      = cnt_q;
        plus_only  = press[KEY_PLUS] & ~press[KEY_MINUS];
        minus_only = press[KEY_MINUS] & ~press[KEY_PLUS];

        if (press[KEY_MODE]) begin
            mode_d = next_mode(mode_q);
        end else begin
            case (mode_q)
                RUN_UP, RUN_DOWN: begin
                    // A saturated speed press changes nothing, so the tick
                    // in that cycle still advances the counter.
                    if (plus_only && speed_q != SPEED_MAX)
                        speed_d = speed_q + 2'd1;
                    else if (minus_only && speed_q != 2'd0)
                        speed_d = speed_q - 2'd1;
                    else if (tick_now)
                        cnt_d = (mode_q == RUN_UP) ? cnt_q + W'(1) : cnt_q - W'(1);
                end
                PAUSE: begin
                    if (minus_only)
                        cnt_d = '0;
                end
                MANUAL: begin
                    if (plus_only)
                        cnt_d = cnt_q + W'(1);
                    else if (minus_only)
                        cnt_d = cnt_q - W'(1);
                end
                default: ;
            endcase
        end

        changed = (mode_d != mode_q) || (speed_d != speed_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= RUN_UP;
            speed_q <= 2'd0;
            cnt_q   <= '0;
            psc_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            speed_q <= speed_d;
            cnt_q   <= cnt_d;
            if (changed) begin
                psc_q  <= '0;
                tick_q <= 1'b0;
            end else begin
                psc_q  <= tick_now ? '0 : psc_q + PRESCALE_W'(1);
                tick_q <= tick_now;
            end
        end
    end

    assign led   = ~cnt_q;
    assign mode  = mode_q;
    assign speed = speed_q;
    assign tick  = tick_q;

endmodule

// File: tb/tb_counter_mode_ctrl.sv
module tb_counter_mode_ctrl;

    localparam int W  = 8;
    localparam int PW = 8;
    localparam int DW = 2;
    localparam int N  = 1 << DW;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   key;
    logic [W-1:0] led;
    logic [1:0]   mode;
    logic [1:0]   speed;
    logic         tick;

    int n_checks = 0;
    int n_fail   = 0;

    counter_mode_ctrl #(.W(W), .PRESCALE_W(PW), .DEBOUNCE_W(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .led   (led),
        .mode  (mode),
        .speed (speed),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Debounce: a key's accepted level flips when the last N synced samples
    // (raw samples delayed two edges) all disagree with it.
    int t = 0;
    int anchor = 0;
    int m_mode = 0, m_speed = 0, m_cnt = 0;
    bit m_tick = 0;
    bit m_p[3];
    bit acc[3];
    bit hist[3][N+1];
    bit started = 0;

    always @(posedge clk) begin : model
        int  period, nm, ns, nc;
        bit  tick_now, chg, pp, pm, win;
        t++;
        if (rst) begin
            started = 1;
            m_mode = 0; m_speed = 0; m_cnt = 0; m_tick = 0;
            anchor = t;
            for (int k = 0; k < 3; k++) begin
                m_p[k] = 0;
                acc[k] = 0;
                for (int j = 0; j <= N; j++) hist[k][j] = 0;
            end
        end else begin
            period   = 1 << (PW - 2 * m_speed);
            tick_now = ((t - anchor) % period) == 0;
            pp = m_p[1] && !m_p[2];
            pm = m_p[2] && !m_p[1];
            nm = m_mode; ns = m_speed; nc = m_cnt;
            if (m_p[0]) nm = (m_mode + 1) % 4;
            else if (m_mode < 2) begin
                if (pp && m_speed < 3) ns = m_speed + 1;
                else if (pm && m_speed > 0) ns = m_speed - 1;
                else if (tick_now) nc = (m_mode == 0) ? m_cnt + 1 : m_cnt - 1;
            end else if (m_mode == 2) begin
                if (pm) nc = 0;
            end else begin
                if (pp) nc = m_cnt + 1;
                else if (pm) nc = m_cnt - 1;
            end
            nc  = nc & ((1 << W) - 1);
            chg = (nm != m_mode) || (ns != m_speed);
            if (chg) begin
                anchor = t;
                m_tick = 0;
            end else begin
                m_tick = tick_now;
            end
            m_mode = nm; m_speed = ns; m_cnt = nc;

            for (int k = 0; k < 3; k++) begin
                win = 1;
                for (int j = 1; j <= N; j++) if (hist[k][j] == acc[k]) win = 0;
                m_p[k] = win && !acc[k];
                if (win) acc[k] = !acc[k];
                for (int j = N; j >= 1; j--) hist[k][j] = hist[k][j-1];
                hist[k][0] = !key[k];
            end
        end
    end

    always @(negedge clk) begin : compare
        if (started) begin
            check("led",   int'(led),   (~m_cnt) & ((1 << W) - 1));
            check("mode",  int'(mode),  m_mode);
            check("speed", int'(speed), m_speed);
            check("tick",  int'(tick),  int'(m_tick));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [2:0] mask, input int hold);
        @(negedge clk);
        key = key & ~mask;
        repeat (hold) @(negedge clk);
        key = key | mask;
        repeat (12) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        key = '1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        key = '1;
        @(negedge clk);
        check("reset_led",  int'(led),  8'hFF);
        check("reset_tick", int'(tick), 0);
        @(negedge clk);
        rst = 1'b0;

        // Idle: four ticks at 256-cycle spacing.
        idle(1030);
        check("idle_led",   int'(led),   8'hFB);
        check("idle_speed", int'(speed), 0);

        // Speed saturates at 3.
        repeat (4) push(3'b010, 10);
        check("speed_sat", int'(speed), 3);

        // Glitch rejected, held press accepted.
        do_reset();
        push(3'b010, 3);
        check("glitch_speed", int'(speed), 0);
        push(3'b010, 6);
        check("hold6_speed", int'(speed), 1);

        // RUN_DOWN wraps 0 -> FF.
        do_reset();
        push(3'b001, 10);
        check("rundown_mode", int'(mode), 1);
        idle(300);
        check("wrap_led", int'(led), 8'h00);

        // PAUSE freezes, minus clears.
        push(3'b001, 10);
        check("pause_mode", int'(mode), 2);
        idle(2000);
        check("pause_led", int'(led), 8'h00);
        push(3'b100, 10);
        check("pause_clear", int'(led), 8'hFF);

        // MANUAL stepping.
        push(3'b001, 10);
        check("manual_mode", int'(mode), 3);
        repeat (3) push(3'b010, 10);
        check("manual_plus3", int'(led), 8'hFC);
        repeat (5) push(3'b100, 10);
        check("manual_minus5", int'(led), 8'h01);
        push(3'b110, 10);
        check("both_led", int'(led), 8'h01);
        push(3'b011, 10);
        check("modeplus_mode", int'(mode), 0);
        check("modeplus_led",  int'(led),  8'h01);

        // Randomised key activity with occasional resets.
        repeat (300) begin
            if ($urandom_range(0, 24) == 0) begin
                do_reset();
            end else begin
                logic [2:0] mask;
                int         hold;
                mask = 3'($urandom_range(1, 7));
                if ($urandom_range(0, 3) != 0) mask = 3'(1 << $urandom_range(0, 2));
                hold = $urandom_range(1, 12);
                @(negedge clk);
                key = ~mask;
                repeat (hold) @(negedge clk);
                key = '1;
                idle($urandom_range(0, 20));
            end
        end

        // Reset during a partial debounce.
        do_reset();
        push(3'b010, 10);
        @(negedge clk);
        key = 3'b110;
        idle(3);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_led",   int'(led),   8'hFF);
        check("midrst_mode",  int'(mode),  0);
        check("midrst_speed", int'(speed), 0);
        check("midrst_tick",  int'(tick),  0);
        rst = 1'b0;
        idle(2);
        key = '1;
        idle(20);
        check("midrst_after_speed", int'(speed), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
